branch_resolve: RTL and testbench
=================================

# branch_resolve

Control-transfer resolution pipeline that consumes the instruction stream produced by the fetch stage (pc_next, instruction) and returns the fetch-redirect pair (pc_branch, pc_source) from its MEM stage. It carries each fetched instruction through IF/ID, ID/EX and EX/MEM registers with valid bits. It decodes beq/bne/j, computes the target and condition, and flushes the three wrong-path instructions when a redirect fires. It also keeps a saturating-free count of taken redirects for performance monitoring.

## Interface
- CNT_W, 16, width of taken-redirect counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- pc_next  input  32  pc+4 of the instruction currently being fetched
- instruction  input  32  instruction currently being fetched
- rs_addr  output  5  IF/ID instruction[25:21], register-file read address A
- rt_addr  output  5  IF/ID instruction[20:16], register-file read address B
- rs_data  input  32  register-file data for rs_addr (combinational, same cycle)
- rt_data  input  32  register-file data for rt_addr
- pc_branch  output  32  redirect target, from EX/MEM register
- pc_source  output  1  1 = fetch loads pc_branch; registered, from EX/MEM
- flush  output  1  equals pc_source; wrong-path kill indication
- taken_count  output  CNT_W  number of redirects issued since reset

## Operation
- Stage IF/ID: every edge captures {pc_next, instruction}, valid <= ~flush.
- Stage ID/EX: captures IF/ID pc_next, opcode (instr[31:26]), imm16, jidx26, rs_data, rt_data; valid <= IF/ID.valid & ~flush.
- Stage EX/MEM: captures target and taken; valid <= ID/EX.valid & ~flush.
- Decode (opcode): 6'h04 beq: taken = (rs == rt). 6'h05 bne: taken = (rs != rt). 6'h02 j: taken = 1. Any other opcode: taken = 0, target don't-care (driven 0).
- Branch target = pc_next + {{14{imm16[15]}}, imm16, 2'b00}, mod 2^32.
- Jump target = {pc_next[31:28], jidx26, 2'b00}.
- pc_source = EX/MEM.valid & EX/MEM.taken. pc_branch = EX/MEM.target when pc_source, else 0.
- Flush kills every younger instruction: IF/ID, ID/EX and EX/MEM load valid=0 on the edge ending a pc_source cycle. pc_source is therefore a single-cycle pulse per redirect. A branch in the shadow of a taken branch never redirects.
- taken_count increments by 1 on each edge where pc_source = 1, and wraps from 2^CNT_W-1 to 0.
- Reset (reset = 0, any time, asynchronous): all valid bits 0, all data registers 0, pc_branch = 0, pc_source = 0, flush = 0, taken_count = 0. rs_addr and rt_addr = 0. An in-flight branch is discarded.

## Timing
- Instruction presented on the input in cycle N, captured at the end of N. It resolves with pc_source high during cycle N+3, and fetch redirects at the end of N+3.
- Redirect penalty is exactly 3 instructions. These are the ones presented in cycles N+1, N+2 and N+3, and all three are flushed.
- rs_addr/rt_addr are valid in cycle N+1. rs_data/rt_data are sampled at the end of N+1.
- Not-taken or non-control instruction: pc_source stays 0 and nothing is flushed.
- Back-to-back control instructions in cycles N and N+1: if N is taken, N+1 is flushed and produces no pulse. If N is not taken, N+1 resolves normally in N+4.
- First instruction after reset release is captured on the first rising edge with reset = 1.

## Test plan
- beq at pc_next 0x0000000C, imm16 = 0x0003, rs_data = rt_data = 5 -> pc_source = 1 for exactly one cycle, 3 cycles after presentation. pc_branch = 0x00000018, taken_count = 1.
- bne at pc_next 0x00000020, imm16 = 0xFFFE, rs_data = 1, rt_data = 2 -> pc_branch = 0x00000018. Same with rs_data = rt_data -> pc_source stays 0 and no flush.
- j with pc_next 0x40000004, jidx26 = 0x0000010 -> pc_branch = 0x40000040. The next three presented beq (all taken) are flushed and produce no pulse.
- Reset pulled low in the cycle after a taken beq is captured -> no pc_source ever asserts. All outputs read 0 immediately, and taken_count = 0.
- CNT_W = 4, 17 taken jumps spaced 4 cycles apart -> taken_count reads 15, then 0, then 1.
- Stream of add/lw opcodes (0x00, 0x23) for 20 cycles -> pc_source = 0 and pc_branch = 0 throughout.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Fetch-side and register-file bus for the branch resolution pipeline.
// The master side is fetch plus the register file; the slave side is branch_resolve.
interface branch_resolve_if;
    // Fetch stream into the pipeline
    logic [31:0] pc_next;
    logic [31:0] instruction;

    // Register-file read ports
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    // Redirect back to fetch
    logic [31:0] pc_branch;
    logic        pc_source;
    logic        flush;

    modport master (
        output pc_next,
        output instruction,
        output rs_data,
        output rt_data,
        input  rs_addr,
        input  rt_addr,
        input  pc_branch,
        input  pc_source,
        input  flush
    );

    modport slave (
        input  pc_next,
        input  instruction,
        input  rs_data,
        input  rt_data,
        output rs_addr,
        output rt_addr,
        output pc_branch,
        output pc_source,
        output flush
    );
endinterface

// File: rtl/branch_resolve.sv
// Control-transfer resolution pipeline: IF/ID -> ID/EX -> EX/MEM.
// Decodes beq/bne/j, resolves target and condition in EX and issues a
// single-cycle redirect from EX/MEM that kills the three younger instructions.
module branch_resolve #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolve_if.slave  bus,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [5:0] OpJ   = 6'h02;
    localparam logic [5:0] OpBeq = 6'h04;
    localparam logic [5:0] OpBne = 6'h05;

    // IF/ID
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;

    // ID/EX
    logic        idex_valid_q, idex_valid_d;
    logic [31:0] idex_pc_q, idex_pc_d;
    logic [5:0]  idex_op_q, idex_op_d;
    logic [15:0] idex_imm_q, idex_imm_d;
    logic [25:0] idex_jidx_q, idex_jidx_d;
    logic [31:0] idex_rs_q, idex_rs_d;
    logic [31:0] idex_rt_q, idex_rt_d;

    // EX/MEM
    logic        exmem_valid_q, exmem_valid_d;
    logic        exmem_taken_q, exmem_taken_d;
    logic [31:0] exmem_target_q, exmem_target_d;

    // Redirect counter
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // EX-stage resolution results
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] br_target;
    logic [31:0] j_target;

    logic        redirect;

    assign redirect = exmem_valid_q & exmem_taken_q;

    // Register-file addresses come straight from the IF/ID instruction
    assign bus.rs_addr = ifid_instr_q[25:21];
    assign bus.rt_addr = ifid_instr_q[20:16];

    // Redirect outputs; target is forced to zero when no redirect is issued
    always_comb begin
        bus.pc_source = redirect;
        bus.flush     = redirect;
        bus.pc_branch = redirect ? exmem_target_q : 32'h0;
    end

    assign taken_count = cnt_q;

    // EX stage: compute both candidate targets and decode the condition
    always_comb begin
        br_target = idex_pc_q + {{14{idex_imm_q[15]}}, idex_imm_q, 2'b00};
        j_target  = {idex_pc_q[31:28], idex_jidx_q, 2'b00};
        ex_taken  = 1'b0;
        ex_target = 32'h0;
        case (idex_op_q)
            OpBeq: begin
                ex_taken  = (idex_rs_q == idex_rt_q);
                ex_target = br_target;
            end
            OpBne: begin
                ex_taken  = (idex_rs_q != idex_rt_q);
                ex_target = br_target;
            end
            OpJ: begin
                ex_taken  = 1'b1;
                ex_target = j_target;
            end
            default: begin
                ex_taken  = 1'b0;
                ex_target = 32'h0;
            end
        endcase
    end

    // Next-state for all pipeline stages; a redirect kills every younger slot
    always_comb begin
        ifid_pc_d      = bus.pc_next;
        ifid_instr_d   = bus.instruction;
        ifid_valid_d   = ~redirect;

        idex_pc_d      = ifid_pc_q;
        idex_op_d      = ifid_instr_q[31:26];
        idex_imm_d     = ifid_instr_q[15:0];
        idex_jidx_d    = ifid_instr_q[25:0];
        idex_rs_d      = bus.rs_data;
        idex_rt_d      = bus.rt_data;
        idex_valid_d   = ifid_valid_q & ~redirect;

        exmem_target_d = ex_target;
        exmem_taken_d  = ex_taken;
        exmem_valid_d  = idex_valid_q & ~redirect;
    end

    // Counter next-state: wraps naturally at 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (redirect) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // IF/ID register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= 32'h0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    // ID/EX register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_valid_q <= 1'b0;
            idex_pc_q    <= 32'h0;
            idex_op_q    <= 6'h0;
            idex_imm_q   <= 16'h0;
            idex_jidx_q  <= 26'h0;
            idex_rs_q    <= 32'h0;
            idex_rt_q    <= 32'h0;
        end else begin
            idex_valid_q <= idex_valid_d;
            idex_pc_q    <= idex_pc_d;
            idex_op_q    <= idex_op_d;
            idex_imm_q   <= idex_imm_d;
            idex_jidx_q  <= idex_jidx_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
        end
    end

    // EX/MEM register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_valid_q  <= 1'b0;
            exmem_taken_q  <= 1'b0;
            exmem_target_q <= 32'h0;
        end else begin
            exmem_valid_q  <= exmem_valid_d;
            exmem_taken_q  <= exmem_taken_d;
            exmem_target_q <= exmem_target_d;
        end
    end

    // Taken-redirect counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_branch_resolve;

    localparam int unsigned CNT_W = 4;

    // Hand-encoded instructions (rs=1, rt=2 for the branches)
    localparam logic [31:0] Nop    = 32'h00000020; // add
    localparam logic [31:0] Lw     = 32'h8C220004; // lw
    localparam logic [31:0] Beq3   = 32'h10220003; // beq imm 0x0003
    localparam logic [31:0] Beq10  = 32'h10220010; // beq imm 0x0010
    localparam logic [31:0] BneM2  = 32'h1422FFFE; // bne imm 0xFFFE
    localparam logic [31:0] J10    = 32'h08000010; // j jidx 0x10

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] taken_count;

    branch_resolve_if bus ();

    branch_resolve #(
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observations taken mid-cycle by tick()
    logic        o_src;
    logic        o_flush;
    logic [31:0] o_br;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [31:0] o_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one instruction for one cycle and record the outputs of that cycle
    task automatic tick(input logic [31:0] pc, input logic [31:0] ins);
        bus.pc_next     = pc;
        bus.instruction = ins;
        #4;
        o_src   = bus.pc_source;
        o_flush = bus.flush;
        o_br    = bus.pc_branch;
        o_rs    = bus.rs_addr;
        o_rt    = bus.rt_addr;
        o_cnt   = 32'(taken_count);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b0;
        bus.pc_next     = 32'h0;
        bus.instruction = 32'h0;
        bus.rs_data     = 32'h0;
        bus.rt_data     = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #5;
        check_eq("rst_src", 32'(bus.pc_source), 32'h0);
        check_eq("rst_flush", 32'(bus.flush), 32'h0);
        check_eq("rst_br", bus.pc_branch, 32'h0);
        check_eq("rst_cnt", 32'(taken_count), 32'h0);
        check_eq("rst_rs", 32'(bus.rs_addr), 32'h0);
        check_eq("rst_rt", 32'(bus.rt_addr), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // beq taken: pulse in N+3 only
        bus.rs_data = 32'd5;
        bus.rt_data = 32'd5;
        tick(32'h0000000C, Beq3);
        check_eq("beq_c0_src", 32'(o_src), 32'h0);
        tick(32'h00000010, Nop);
        check_eq("beq_c1_rs", 32'(o_rs), 32'd1);
        check_eq("beq_c1_rt", 32'(o_rt), 32'd2);
        check_eq("beq_c1_src", 32'(o_src), 32'h0);
        tick(32'h00000014, Nop);
        check_eq("beq_c2_src", 32'(o_src), 32'h0);
        tick(32'h00000018, Nop);
        check_eq("beq_c3_src", 32'(o_src), 32'h1);
        check_eq("beq_c3_flush", 32'(o_flush), 32'h1);
        check_eq("beq_c3_br", o_br, 32'h00000018);
        tick(32'h00000018, Nop);
        check_eq("beq_c4_src", 32'(o_src), 32'h0);
        check_eq("beq_c4_br", o_br, 32'h0);
        check_eq("beq_c4_cnt", o_cnt, 32'd1);

        // bne taken with negative offset
        bus.rs_data = 32'd1;
        bus.rt_data = 32'd2;
        tick(32'h00000020, BneM2);
        tick(32'h00000024, Nop);
        tick(32'h00000028, Nop);
        tick(32'h0000002C, Nop);
        check_eq("bne_c3_src", 32'(o_src), 32'h1);
        check_eq("bne_c3_br", o_br, 32'h00000018);
        tick(32'h00000018, Nop);
        check_eq("bne_c4_cnt", o_cnt, 32'd2);

        // bne not taken, followed by a taken beq that must not be flushed
        bus.rs_data = 32'd7;
        bus.rt_data = 32'd7;
        tick(32'h00000020, BneM2);
        tick(32'h00000024, Beq10);
        check_eq("bnent_c1_src", 32'(o_src), 32'h0);
        tick(32'h00000028, Nop);
        check_eq("bnent_c2_src", 32'(o_src), 32'h0);
        tick(32'h0000002C, Nop);
        check_eq("bnent_c3_src", 32'(o_src), 32'h0);
        check_eq("bnent_c3_flush", 32'(o_flush), 32'h0);
        tick(32'h00000030, Nop);
        check_eq("beq2_c4_src", 32'(o_src), 32'h1);
        check_eq("beq2_c4_br", o_br, 32'h00000064);
        tick(32'h00000064, Nop);
        check_eq("beq2_c5_src", 32'(o_src), 32'h0);
        check_eq("beq2_c5_cnt", o_cnt, 32'd3);

        // j followed by three taken beq in its shadow
        tick(32'h40000004, J10);
        tick(32'h40000008, Beq3);
        tick(32'h4000000C, Beq3);
        tick(32'h40000010, Beq3);
        check_eq("j_c3_src", 32'(o_src), 32'h1);
        check_eq("j_c3_br", o_br, 32'h40000040);
        for (int i = 4; i < 8; i++) begin
            tick(32'h40000044, Nop);
            check_eq($sformatf("jshadow_c%0d_src", i), 32'(o_src), 32'h0);
        end
        check_eq("j_cnt", o_cnt, 32'd4);

        // Reset asserted the cycle after a taken beq is captured
        bus.rs_data = 32'd9;
        bus.rt_data = 32'd9;
        tick(32'h00000100, Beq3);
        reset = 1'b0;
        tick(32'h00000104, Nop);
        check_eq("rmid_src", 32'(o_src), 32'h0);
        check_eq("rmid_br", o_br, 32'h0);
        check_eq("rmid_rs", 32'(o_rs), 32'h0);
        check_eq("rmid_rt", 32'(o_rt), 32'h0);
        check_eq("rmid_cnt", o_cnt, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(32'h00000108, Nop);
            check_eq($sformatf("rpost_%0d_src", i), 32'(o_src), 32'h0);
        end

        // Counter wrap with CNT_W = 4
        for (int k = 0; k < 15; k++) begin
            tick(32'h00000100, J10);
            repeat (3) tick(32'h00000104, Nop);
        end
        tick(32'h00000040, Nop);
        check_eq("wrap_15", o_cnt, 32'd15);
        tick(32'h00000100, J10);
        repeat (3) tick(32'h00000104, Nop);
        tick(32'h00000040, Nop);
        check_eq("wrap_0", o_cnt, 32'd0);
        tick(32'h00000100, J10);
        repeat (3) tick(32'h00000104, Nop);
        tick(32'h00000040, Nop);
        check_eq("wrap_1", o_cnt, 32'd1);

        // Non-control stream never redirects
        bus.rs_data = 32'd3;
        bus.rt_data = 32'd3;
        for (int i = 0; i < 20; i++) begin
            tick(32'h00000200 + 32'(4 * i), (i % 2 == 0) ? Nop : Lw);
            check_eq($sformatf("alu_%0d_src", i), 32'(o_src), 32'h0);
            check_eq($sformatf("alu_%0d_br", i), o_br, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
